// File: rtl/uart_packet_decoder_if.sv
// ----------------------------------------------------------------------------
// uart_packet_decoder_if
// Bundles the two byte streams around the packet decoder:
//   RxData/RxReady/RxAck       : 4-phase byte intake from the UART receiver
//   OutData/OutValid/OutLast/  : valid/ready payload stream to downstream
//   OutReady
// Modports:
//   slave  : decoder view (consumes Rx bytes, produces Out bytes)
//   master : environment view (produces Rx bytes, consumes Out bytes)
// ----------------------------------------------------------------------------
interface uart_packet_decoder_if;
  logic [7:0] RxData;
  logic       RxReady;
  logic       RxAck;
  logic [7:0] OutData;
  logic       OutValid;
  logic       OutLast;
  logic       OutReady;

  modport slave (
    input  RxData, RxReady, OutReady,
    output RxAck, OutData, OutValid, OutLast
  );

  modport master (
    output RxData, RxReady, OutReady,
    input  RxAck, OutData, OutValid, OutLast
  );
endinterface

// File: rtl/uart_packet_decoder.sv
// ----------------------------------------------------------------------------
// uart_packet_decoder
// Hunts for SYNC, then decodes LEN, LEN payload bytes and CHK from a byte
// stream. A frame is good when (LEN + payload + CHK) mod 256 == 0; good
// frames are replayed from an internal 16x8 buffer on a valid/ready stream.
// Ports:
//   Clk        : system clock, rising edge
//   Reset      : synchronous, active-low
//   bus        : uart_packet_decoder_if.slave (Rx intake + Out stream)
//   LenErr     : one-cycle pulse, LEN of 0 or above MAXLEN
//   ChkErr     : one-cycle pulse, checksum mismatch
//   ToErr      : one-cycle pulse, inter-byte timeout inside a frame
//   FrameCount : frames fully emitted, wraps 255->0
// ----------------------------------------------------------------------------
module uart_packet_decoder #(
  parameter logic [7:0]  SYNC   = 8'hA5,
  parameter int unsigned MAXLEN = 16,
  parameter logic [15:0] TOUT   = 16'd50000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  uart_packet_decoder_if.slave bus,
  output logic                 LenErr,
  output logic                 ChkErr,
  output logic                 ToErr,
  output logic [7:0]           FrameCount
);

  localparam logic [7:0]  MAXLEN_B = 8'(MAXLEN);
  localparam logic [15:0] TOUT_M1  = TOUT - 16'd1;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_EMIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_ack;
  logic [7:0]  r_sum;
  logic [4:0]  r_idx;
  logic [4:0]  r_len;
  logic [15:0] r_tcnt;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_out_last;
  logic [7:0]  r_fc;
  logic        r_len_err;
  logic        r_chk_err;
  logic        r_to_err;
  logic [7:0]  r_buf [16];

  logic        w_take;
  logic        w_xfer;
  logic        w_tout_hit;
  logic        w_len_err;
  logic        w_chk_err;
  logic        w_to_err;
  logic        w_emit_start;
  logic [7:0]  w_byte;
  logic [7:0]  w_sum_chk;
  logic [4:0]  w_idx_inc;
  logic [4:0]  w_len_m1;

  assign w_byte     = bus.RxData;
  assign w_sum_chk  = r_sum + w_byte;
  assign w_idx_inc  = r_idx + 5'd1;
  assign w_len_m1   = r_len - 5'd1;
  // A new byte is only taken once the previous handshake has fully closed
  // (RxAck low); EMIT never accepts, which backpressures the receiver.
  assign w_take     = bus.RxReady & ~r_ack & (r_state != S_EMIT);
  assign w_xfer     = r_out_valid & bus.OutReady;
  assign w_tout_hit = (r_tcnt == TOUT_M1);

  // ---- state register ----
  always_ff @(posedge Clk) begin
    if (!Reset) r_state <= S_HUNT;
    else        r_state <= w_state_nxt;
  end

  // ---- next state and event decode ----
  always_comb begin
    w_state_nxt  = r_state;
    w_len_err    = 1'b0;
    w_chk_err    = 1'b0;
    w_to_err     = 1'b0;
    w_emit_start = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (w_take && (w_byte == SYNC)) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        if (w_take) begin
          if ((w_byte == 8'd0) || (w_byte > MAXLEN_B)) begin
            w_len_err   = 1'b1;
            w_state_nxt = S_HUNT;
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end else if (w_tout_hit) begin
          w_to_err    = 1'b1;
          w_state_nxt = S_HUNT;
        end
      end
      S_PAYLOAD: begin
        if (w_take) begin
          if (r_idx == w_len_m1) w_state_nxt = S_CHK;
        end else if (w_tout_hit) begin
          w_to_err    = 1'b1;
          w_state_nxt = S_HUNT;
        end
      end
      S_CHK: begin
        if (w_take) begin
          if (w_sum_chk == 8'd0) begin
            w_emit_start = 1'b1;
            w_state_nxt  = S_EMIT;
          end else begin
            w_chk_err   = 1'b1;
            w_state_nxt = S_HUNT;
          end
        end else if (w_tout_hit) begin
          w_to_err    = 1'b1;
          w_state_nxt = S_HUNT;
        end
      end
      S_EMIT: begin
        if (w_xfer && r_out_last) w_state_nxt = S_HUNT;
      end
      default: w_state_nxt = S_HUNT;
    endcase
  end

  // ---- inter-byte timeout: runs only while inside a frame ----
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_tcnt <= 16'd0;
    end else if (w_take || (w_state_nxt == S_HUNT) ||
                 (r_state == S_HUNT) || (r_state == S_EMIT)) begin
      r_tcnt <= 16'd0;
    end else begin
      r_tcnt <= r_tcnt + 16'd1;
    end
  end

  // ---- payload buffer (contents survive reset; index/len gate its use) ----
  always_ff @(posedge Clk) begin
    if ((r_state == S_PAYLOAD) && w_take) r_buf[r_idx[3:0]] <= w_byte;
  end

  // ---- intake handshake, checksum, emit stream, status ----
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_ack       <= 1'b0;
      r_sum       <= 8'd0;
      r_idx       <= 5'd0;
      r_len       <= 5'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_fc        <= 8'd0;
      r_len_err   <= 1'b0;
      r_chk_err   <= 1'b0;
      r_to_err    <= 1'b0;
    end else begin
      r_len_err <= w_len_err;
      r_chk_err <= w_chk_err;
      r_to_err  <= w_to_err;

      if (w_take)              r_ack <= 1'b1;
      else if (!bus.RxReady)   r_ack <= 1'b0;

      case (r_state)
        S_LEN: begin
          if (w_take) begin
            r_len <= w_byte[4:0];
            r_sum <= w_byte;
            r_idx <= 5'd0;
          end
        end
        S_PAYLOAD: begin
          if (w_take) begin
            r_sum <= w_sum_chk;
            r_idx <= w_idx_inc;
          end
        end
        S_CHK: begin
          // First byte is presented on the cycle right after the CHK capture.
          if (w_emit_start) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_buf[0];
            r_out_last  <= (r_len == 5'd1);
            r_idx       <= 5'd0;
          end
        end
        S_EMIT: begin
          if (w_xfer) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_fc        <= r_fc + 8'd1;
            end else begin
              r_idx      <= w_idx_inc;
              r_out_data <= r_buf[w_idx_inc[3:0]];
              r_out_last <= (w_idx_inc == w_len_m1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.RxAck    = r_ack;
  assign bus.OutData  = r_out_data;
  assign bus.OutValid = r_out_valid;
  assign bus.OutLast  = r_out_last;
  assign LenErr       = r_len_err;
  assign ChkErr       = r_chk_err;
  assign ToErr        = r_to_err;
  assign FrameCount   = r_fc;

endmodule

// File: doc/uart_packet_decoder.md
UART_PACKET_DECODER -- requirements
Module: uart_packet_decoder

Interface
REQ-001 SHALL have parameter SYNC, default 8'hA5, frame sync byte.
REQ-002 SHALL have parameter MAXLEN, default 16, maximum payload bytes (1..16).
REQ-003 SHALL have parameter TOUT, default 16'd50000, inter-byte timeout in Clk cycles.
REQ-004 SHALL have port Clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port RxData  input  8  byte from upstream UART receiver.
REQ-007 SHALL have port RxReady  input  1  high while RxData holds an unconsumed byte.
REQ-008 SHALL have port RxAck  output  1  consume acknowledge to receiver.
REQ-009 SHALL have port OutData  output  8  payload byte of a validated frame.
REQ-010 SHALL have port OutValid  output  1  OutData valid.
REQ-011 SHALL have port OutLast  output  1  marks final payload byte; qualified by OutValid.
REQ-012 SHALL have port OutReady  input  1  downstream accepts OutData when high with OutValid.
REQ-013 SHALL have port LenErr, ChkErr, ToErr  output  1 each  one-cycle error pulses.
REQ-014 SHALL have port FrameCount  output  8  count of frames fully emitted, wraps 255->0.

Function
REQ-015 Frame format SHALL be: SYNC, LEN, LEN payload bytes, CHK; valid iff (LEN + payload + CHK) mod 256 == 0.
REQ-016 Byte intake SHALL be 4-phase: on RxReady high with RxAck low in an accepting state, capture RxData and raise RxAck; hold RxAck high until RxReady sampled low, then drop it; capture no further byte until RxAck is low.
REQ-017 States SHALL be HUNT, LEN, PAYLOAD, CHK, EMIT; accepting states are HUNT, LEN, PAYLOAD, CHK.
REQ-018 HUNT: byte == SYNC -> LEN; any other byte discarded, stay HUNT.
REQ-019 LEN: byte 0 or > MAXLEN -> pulse LenErr, -> HUNT; else store LEN, init running sum to LEN, index 0, -> PAYLOAD.
REQ-020 PAYLOAD: write byte to internal 16x8 buffer at index, add to 8-bit running sum (carry discarded), increment index; after LEN-th byte -> CHK.
REQ-021 CHK: sum + byte == 0 mod 256 -> EMIT; else pulse ChkErr, -> HUNT, buffer discarded.
REQ-022 A SYNC value received in LEN/PAYLOAD/CHK SHALL be treated as data, not resync.
REQ-023 EMIT: present buffer[0..LEN-1] in order; OutValid high continuously; advance only on OutValid & OutReady; OutLast high on byte LEN-1.
REQ-024 OutData/OutLast SHALL be stable while OutValid high and OutReady low.
REQ-025 On final transfer in EMIT: increment FrameCount, drop OutValid next cycle, -> HUNT.
REQ-026 RxAck SHALL not be raised in EMIT; upstream bytes arriving then are backpressured, and receiver-side loss is permitted.
REQ-027 Timeout counter SHALL clear on each captured byte and on entry to HUNT; in LEN/PAYLOAD/CHK reaching TOUT -> pulse ToErr, -> HUNT; inactive in HUNT and EMIT.
REQ-028 Error pulses SHALL be exactly one cycle, mutually exclusive, registered.
REQ-029 First OutValid SHALL assert 1 cycle after CHK byte capture.

Reset
REQ-030 While Reset low at a Clk edge: state HUNT, RxAck 0, OutValid 0, OutLast 0, OutData 0, LenErr/ChkErr/ToErr 0, FrameCount 0, sum/index/timeout 0.
REQ-031 Reset mid-frame or mid-EMIT SHALL abandon the frame with no emission; buffer contents need not be cleared.
REQ-032 First byte accept SHALL be possible on the first edge after Reset returns high.

Verification
REQ-033 Bytes A5 02 11 22 CB, OutReady=1 -> OutData 11 then 22 (OutLast on 22), FrameCount 0->1, no errors.
REQ-034 Bytes A5 02 11 22 CC -> ChkErr one pulse, no OutValid, FrameCount unchanged; following A5 01 7F 80 -> emits 7F with OutLast.
REQ-035 Bytes A5 00 and A5 11 -> LenErr pulse each, state HUNT.
REQ-036 A5 03 01, then idle TOUT cycles -> ToErr pulse, back to HUNT; RxAck never stuck high.
REQ-037 Valid 16-byte frame with OutReady toggled 1/0 per cycle -> all 16 bytes in order, held stable while stalled, OutLast only on byte 16.
REQ-038 Reset low during PAYLOAD of A5 04 ... -> all outputs at reset values, subsequent valid frame decoded normally.
